// File: rtl/mips_debug_ctrl.sv
// Byte-stream debug controller for top_mips: program load, run/step,
// and post-run streaming of the pipeline latch snapshot and cycle count.
module mips_debug_ctrl #(
   parameter int LEN     = 32,
   parameter int NB_ADDR = 8,
   parameter int NB_DUMP = 453,
   parameter int NB_CYC  = 32
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [7:0]         i_rx_data,
   input  logic               i_rx_valid,
   output logic               o_rx_ready,
   output logic [7:0]         o_tx_data,
   output logic               o_tx_valid,
   input  logic               i_tx_ready,
   output logic               o_mips_en,
   output logic               o_mips_rst,
   output logic               o_imem_we,
   output logic [NB_ADDR-1:0] o_imem_addr,
   output logic [LEN-1:0]     o_imem_data,
   input  logic               i_halt,
   input  logic [NB_DUMP-1:0] i_dump
);

   localparam int NBW = LEN / 8;
   localparam int NBC = NB_CYC / 8;
   localparam int NBD = (NB_DUMP + 7) / 8;
   localparam int NBT = NBC + NBD;
   localparam int BW  = $clog2(NBW + 1);
   localparam int TW  = $clog2(NBT + 1);

   typedef enum logic [2:0] {
      IDLE, LOAD_LEN, LOAD_WORD, RUN, STEP, DUMP
   } state_t;

   state_t               state_q, state_d;
   logic [LEN-1:0]       word_q, word_d;
   logic [BW-1:0]        bcnt_q, bcnt_d;
   logic [7:0]           left_q, left_d;
   logic [NB_ADDR-1:0]   addr_q, addr_d;
   logic [NB_ADDR-1:0]   waddr_q, waddr_d;
   logic                 we_q, we_d;
   logic                 rstp_q, rstp_d;
   logic [NB_CYC-1:0]    cyc_q, cyc_d;
   logic [8*NBT-1:0]     snap_q, snap_d;
   logic                 snapd_q, snapd_d;
   logic [TW-1:0]        tcnt_q, tcnt_d;

   logic                 rx_acc;
   logic                 tx_acc;
   logic [8*NBD-1:0]     dpad;
   logic [NB_CYC-1:0]    crev;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         word_q  <= '0;
         bcnt_q  <= '0;
         left_q  <= '0;
         addr_q  <= '0;
         waddr_q <= '0;
         we_q    <= 1'b0;
         rstp_q  <= 1'b0;
         cyc_q   <= '0;
         snap_q  <= '0;
         snapd_q <= 1'b0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         bcnt_q  <= bcnt_d;
         left_q  <= left_d;
         addr_q  <= addr_d;
         waddr_q <= waddr_d;
         we_q    <= we_d;
         rstp_q  <= rstp_d;
         cyc_q   <= cyc_d;
         snap_q  <= snap_d;
         snapd_q <= snapd_d;
         tcnt_q  <= tcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      bcnt_d  = bcnt_q;
      left_d  = left_q;
      addr_d  = addr_q;
      waddr_d = waddr_q;
      we_d    = 1'b0;
      rstp_d  = 1'b0;
      cyc_d   = cyc_q;
      snap_d  = snap_q;
      snapd_d = snapd_q;
      tcnt_d  = tcnt_q;

      o_rx_ready = ~i_rst & ((state_q == IDLE) |
                             (state_q == LOAD_LEN) |
                             (state_q == LOAD_WORD));
      o_tx_valid = ~i_rst & (state_q == DUMP) & snapd_q;
      o_mips_en  = ~i_rst & (((state_q == RUN) & ~i_halt) |
                             (state_q == STEP));
      rx_acc = i_rx_valid & o_rx_ready;
      tx_acc = o_tx_valid & i_tx_ready;

      // Counter goes out MSB byte first, so byte-reverse it into slot 0..NBC-1
      dpad = '0;
      dpad[NB_DUMP-1:0] = i_dump;
      crev = '0;
      for (int i = 0; i < NBC; i++) begin
         crev[8*i +: 8] = cyc_q[8*(NBC-1-i) +: 8];
      end

      if (o_mips_en && (cyc_q != '1)) begin
         cyc_d = cyc_q + NB_CYC'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (rx_acc) begin
               case (i_rx_data)
                  8'h01:   state_d = LOAD_LEN;
                  8'h02:   state_d = RUN;
                  8'h03:   state_d = STEP;
                  8'h04:   state_d = DUMP;
                  default: state_d = IDLE;
               endcase
            end
         end
         LOAD_LEN: begin
            if (rx_acc) begin
               if (i_rx_data == 8'd0) begin
                  state_d = IDLE;
               end else begin
                  left_d  = i_rx_data;
                  addr_d  = '0;
                  bcnt_d  = '0;
                  state_d = LOAD_WORD;
               end
            end
         end
         LOAD_WORD: begin
            if (rx_acc) begin
               word_d = LEN'({word_q, i_rx_data});
               if (bcnt_q == BW'(NBW - 1)) begin
                  bcnt_d  = '0;
                  we_d    = 1'b1;
                  waddr_d = addr_q;
                  addr_d  = addr_q + NB_ADDR'(1);
                  left_d  = left_q - 8'd1;
                  if (left_q == 8'd1) begin
                     rstp_d  = 1'b1;
                     cyc_d   = '0;
                     state_d = IDLE;
                  end
               end else begin
                  bcnt_d = bcnt_q + BW'(1);
               end
            end
         end
         RUN: begin
            if (i_halt) state_d = DUMP;
         end
         STEP: begin
            state_d = DUMP;
         end
         DUMP: begin
            if (!snapd_q) begin
               snap_d  = {dpad, crev};
               snapd_d = 1'b1;
               tcnt_d  = '0;
            end else if (tx_acc) begin
               snap_d = snap_q >> 8;
               tcnt_d = tcnt_q + TW'(1);
               if (tcnt_q == TW'(NBT - 1)) begin
                  snapd_d = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_tx_data   = snap_q[7:0];
   assign o_mips_rst  = i_rst | rstp_q;
   assign o_imem_we   = we_q & ~i_rst;
   assign o_imem_addr = waddr_q;
   assign o_imem_data = word_q;

endmodule

// File: tb/tb_mips_debug_ctrl.sv
// Directed bench for mips_debug_ctrl: scoreboard of expected writes and
// tx bytes derived from the command stream, plus literal spot checks.
module tb_mips_debug_ctrl;

   typedef struct packed {
      logic [7:0]  a;
      logic [31:0] d;
   } wr_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [7:0]   rx_data = 8'h00;
   logic         rx_valid = 1'b0;
   logic         tx_ready = 1'b1;
   logic         halt = 1'b0;
   logic [452:0] dumpv = '0;

   logic         rx_ready, tx_valid, mips_en, mips_rst, imem_we;
   logic [7:0]   tx_data;
   logic [7:0]   imem_addr;
   logic [31:0]  imem_data;

   logic         w_rx_ready, w_tx_valid, w_en, w_rst, w_we;
   logic [7:0]   w_tx_data;
   logic [0:0]   w_addr;
   logic [31:0]  w_data;

   int errors = 0;
   int checks = 0;
   int en_cnt = 0;
   int rstp_cnt = 0;
   int model_cyc = 0;
   bit toggle = 1'b0;

   wr_t        exp_we[$];
   wr_t        obs_we[$];
   logic [7:0] exp_tx[$];
   logic [7:0] obs_tx[$];
   bit         w_addr_log[$];

   mips_debug_ctrl dut (
      .i_clk(clk), .i_rst(rst),
      .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
      .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
      .o_mips_en(mips_en), .o_mips_rst(mips_rst),
      .o_imem_we(imem_we), .o_imem_addr(imem_addr),
      .o_imem_data(imem_data),
      .i_halt(halt), .i_dump(dumpv)
   );

   mips_debug_ctrl #(.NB_ADDR(1)) dut_w (
      .i_clk(clk), .i_rst(rst),
      .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(w_rx_ready),
      .o_tx_data(w_tx_data), .o_tx_valid(w_tx_valid), .i_tx_ready(tx_ready),
      .o_mips_en(w_en), .o_mips_rst(w_rst),
      .o_imem_we(w_we), .o_imem_addr(w_addr),
      .o_imem_data(w_data),
      .i_halt(halt), .i_dump(dumpv)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   task automatic fail_to(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout want completion", name);
   endtask

   function automatic logic [31:0] wgen(input int s, input int i);
      logic [7:0] b;
      b = i[7:0];
      if (s == 0) return (i == 0) ? 32'h12345678 : 32'hAABBCCDD;
      return {b, ~b, b ^ s[7:0], 8'hC3};
   endfunction

   // Checker: sampled 1 time unit after the falling edge
   initial begin
      logic       pv;
      logic       pr;
      logic [7:0] pd;
      wr_t        e;
      logic [7:0] eb;
      pv = 1'b0; pr = 1'b1; pd = 8'h00;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            pv = 1'b0;
            chk("rst_outs",
                {tx_valid, mips_en, imem_we, rx_ready, mips_rst,
                 w_tx_valid, w_en, w_we},
                64'b0000_1000);
         end else begin
            if (imem_we || w_we) begin
               if (exp_we.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL we_extra: got addr %0h data %0h want none",
                           imem_addr, imem_data);
               end else begin
                  e = exp_we.pop_front();
                  chk("we_main", {imem_we, imem_addr, imem_data},
                      {1'b1, e.a, e.d});
                  chk("we_wrap", {w_we, w_addr, w_data},
                      {1'b1, e.a[0], e.d});
               end
               obs_we.push_back({imem_addr, imem_data});
               w_addr_log.push_back(w_addr[0]);
            end
            if (tx_valid && tx_ready) begin
               if (exp_tx.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL tx_extra: got %0h want none", tx_data);
               end else begin
                  eb = exp_tx.pop_front();
                  chk("tx_byte", tx_data, eb);
               end
               obs_tx.push_back(tx_data);
            end
            if (pv && !pr) chk("tx_hold", {tx_valid, tx_data}, {1'b1, pd});
            pv = tx_valid; pr = tx_ready; pd = tx_data;
            if (mips_en) en_cnt++;
            if (mips_rst) rstp_cnt++;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         tx_ready = toggle ? ~tx_ready : 1'b1;
      end
   end

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      rx_data = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) fail_to("rx_accept");
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic push_dump();
      logic [31:0]  c;
      logic [455:0] pad;
      c = model_cyc;
      pad = {3'b000, dumpv};
      obs_tx.delete();
      for (int k = 0; k < 4; k++) exp_tx.push_back(c[8*(3-k) +: 8]);
      for (int j = 0; j < 57; j++) exp_tx.push_back(pad[8*j +: 8]);
   endtask

   task automatic wait_dump();
      int n;
      n = 0;
      while ((exp_tx.size() != 0 || !rx_ready) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) fail_to("dump_done");
      repeat (4) @(negedge clk);
      chk("dump_len", obs_tx.size(), 61);
   endtask

   task automatic load(input int n, input int s);
      int r0, e0;
      logic [31:0] w;
      r0 = rstp_cnt;
      e0 = en_cnt;
      obs_we.delete();
      w_addr_log.delete();
      send(8'h01);
      send(n[7:0]);
      for (int i = 0; i < n; i++) begin
         w = wgen(s, i);
         exp_we.push_back({i[7:0], w});
         for (int k = 3; k >= 0; k--) send(w[8*k +: 8]);
      end
      repeat (3) @(negedge clk);
      if (n > 0) model_cyc = 0;
      chk("we_drained", exp_we.size(), 0);
      chk("load_rstp", rstp_cnt - r0, (n > 0) ? 1 : 0);
      chk("load_no_en", en_cnt - e0, 0);
      chk("load_rdy", rx_ready, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish want finish");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int n;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst", {rx_ready, mips_rst, tx_valid, mips_en}, 4'b1000);
      @(negedge clk);

      load(2, 0);
      chk("lit_w0", obs_we[0], {8'h00, 32'h12345678});
      chk("lit_w1", obs_we[1], {8'h01, 32'hAABBCCDD});

      e0 = en_cnt;
      dumpv = {$urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom, $urandom, $urandom};
      model_cyc += 1;
      push_dump();
      toggle = 1'b1;
      send(8'h03);
      wait_dump();
      toggle = 1'b0;
      chk("step_en", en_cnt - e0, 1);
      chk("lit_step_cnt", {obs_tx[0], obs_tx[1], obs_tx[2], obs_tx[3]},
          32'h00000001);

      load(2, 0);
      e0 = en_cnt;
      halt = 1'b0;
      model_cyc += 10;
      push_dump();
      send(8'h02);
      repeat (10) @(negedge clk);
      halt = 1'b1;
      wait_dump();
      chk("run_en", en_cnt - e0, 10);
      chk("lit_run_cnt", {obs_tx[0], obs_tx[1], obs_tx[2], obs_tx[3]},
          32'h0000000A);

      e0 = en_cnt;
      dumpv = ~dumpv;
      push_dump();
      send(8'h02);
      wait_dump();
      halt = 1'b0;
      chk("halt_entry_en", en_cnt - e0, 0);
      chk("lit_halt_cnt", obs_tx[3], 8'h0A);

      dumpv = dumpv ^ {15{32'h5A5AC3C3}};
      push_dump();
      send(8'h7F);
      chk("unk_rdy", rx_ready, 1);
      send(8'h04);
      wait_dump();
      chk("lit_unk_cnt", {obs_tx[0], obs_tx[1], obs_tx[2], obs_tx[3]},
          32'h0000000A);

      push_dump();
      send(8'h04);
      n = 0;
      while (obs_tx.size() < 10 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) fail_to("mid_dump");
      rst = 1'b1;
      exp_tx.delete();
      #1;
      chk("rst_mips_rst", mips_rst, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_cyc = 0;
      #1;
      chk("rst_after", {tx_valid, rx_ready, mips_rst}, 3'b010);
      repeat (80) @(negedge clk);

      push_dump();
      send(8'h04);
      wait_dump();
      chk("lit_rst_cnt", {obs_tx[0], obs_tx[1], obs_tx[2], obs_tx[3]},
          32'h00000000);

      load(255, 1);
      chk("lit_w254_addr", obs_we[254].a, 8'hFE);
      load(3, 2);
      chk("lit_wrap", {w_addr_log[0], w_addr_log[1], w_addr_log[2]},
          3'b010);
      load(0, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
